fifo_uart_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_baud_cnt.sv | 45 ++++
 rtl/fifo_uart_tx.sv | 147 ++++++++++++++
 tb/tb_fifo_uart_tx.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : uart_pkg                                                   |
// | Purpose : Shared types and constants for the FIFO-fed UART 8N1       |
// |           transmitter (state encoding, line levels, frame length).   |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  // start + 8 data + stop
  localparam int   FRAME_BITS = 10;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_baud_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : uart_baud_cnt                                              |
// | Purpose : Bit-period counter. Counts 0..CLKS_PER_BIT-1 while enabled |
// |           and flags the last cycle of every bit period.              |
// | Ports   : clk      - system clock                                    |
// |           reset    - synchronous active-high reset                   |
// |           en       - count enable (a frame is in progress)           |
// |           clear    - restart the bit period at zero                  |
// |           bit_tick - high in the last cycle of each bit              |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clear,
  output logic bit_tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] c_LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last   = (r_cnt == c_LAST);
  // The tick does not depend on clear, so the pop logic that drives clear
  // from this tick forms no combinational loop.
  assign bit_tick = en && w_last;

  always_ff @(posedge clk) begin
    if (reset || clear || !en) begin
      r_cnt <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule : uart_baud_cnt
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : fifo_uart_tx                                               |
// | Purpose : Drains a first-word-fall-through FIFO and serialises each  |
// |           byte as a UART 8N1 frame. Frames run back-to-back while    |
// |           data remains; the line idles high once the FIFO is empty.  |
// | Ports   : clk     - system clock, rising edge                        |
// |           reset   - synchronous active-high reset                    |
// |           empty   - FIFO empty flag                                  |
// |           rdata   - FIFO head word (valid while empty=0)             |
// |           rd_en   - FIFO pop strobe, one cycle per byte              |
// |           tx      - serial line, idle high                           |
// |           tx_busy - high from start bit through stop bit             |
// |           tx_done - pulse in the final cycle of each stop bit        |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rd_en,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_W-1:0] c_LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  uart_state_t           r_state,   w_state_nxt;
  logic [DATA_WIDTH-1:0] r_shift,   w_shift_nxt;
  logic [BIT_W-1:0]      r_bit_idx, w_bit_idx_nxt;
  logic                  r_tx,      w_tx_nxt;
  logic                  r_busy,    w_busy_nxt;
  logic                  w_bit_tick;
  logic                  w_baud_en;
  logic                  w_stop_end;
  logic                  w_pop;

  assign w_baud_en = (r_state != IDLE);

  uart_baud_cnt #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .reset    (reset),
    .en       (w_baud_en),
    .clear    (w_pop),
    .bit_tick (w_bit_tick)
  );

  // Pops happen only from IDLE or at the very end of a stop bit; the reset
  // term keeps the FIFO untouched while reset is held.
  assign w_stop_end = (r_state == STOP) && w_bit_tick;
  assign w_pop      = !reset && !empty && ((r_state == IDLE) || w_stop_end);

  assign rd_en   = w_pop;
  assign tx_done = !reset && w_stop_end;
  assign tx      = r_tx;
  assign tx_busy = r_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_tx      <= STOP_BIT;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_tx      <= w_tx_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  // tx is registered, so each branch loads the level of the bit that
  // begins at the coming edge.
  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_idx_nxt = r_bit_idx;
    w_tx_nxt      = r_tx;
    w_busy_nxt    = r_busy;

    case (r_state)
      IDLE: begin
        if (w_pop) begin
          w_state_nxt = START;
          w_shift_nxt = rdata;
          w_tx_nxt    = START_BIT;
          w_busy_nxt  = 1'b1;
        end
      end

      START: begin
        if (w_bit_tick) begin
          w_state_nxt   = DATA;
          w_bit_idx_nxt = '0;
          w_tx_nxt      = r_shift[0];
        end
      end

      DATA: begin
        if (w_bit_tick) begin
          w_shift_nxt = r_shift >> 1;
          if (r_bit_idx == c_LAST_BIT) begin
            w_state_nxt   = STOP;
            w_bit_idx_nxt = '0;
            w_tx_nxt      = STOP_BIT;
          end else begin
            w_bit_idx_nxt = r_bit_idx + BIT_W'(1);
            w_tx_nxt      = r_shift[1];
          end
        end
      end

      STOP: begin
        if (w_bit_tick) begin
          if (w_pop) begin
            // Next byte follows with no idle gap.
            w_state_nxt = START;
            w_shift_nxt = rdata;
            w_tx_nxt    = START_BIT;
          end else begin
            w_state_nxt = IDLE;
            w_tx_nxt    = STOP_BIT;
            w_busy_nxt  = 1'b0;
          end
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule : fifo_uart_tx
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_fifo_uart_tx                                            |
// | Purpose : Self-checking bench for fifo_uart_tx with a queue-based    |
// |           FIFO, a frame-position reference model and a UART monitor. |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_fifo_uart_tx;
  import uart_pkg::*;

  localparam int C     = 4;
  localparam int DW    = 8;
  localparam int FLEN  = FRAME_BITS * C;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          empty = 1'b1;
  logic [DW-1:0] rdata = '0;
  logic          rd_en, tx, tx_busy, tx_done;

  fifo_uart_tx #(
    .DATA_WIDTH   (DW),
    .CLKS_PER_BIT (C)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .empty   (empty),
    .rdata   (rdata),
    .rd_en   (rd_en),
    .tx      (tx),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc   = 0;
  logic [7:0] fq[$];
  logic [7:0] rxq[$];
  int         m_pos = -1;
  logic [7:0] m_byte = '0;
  logic       e_rd, e_tx;
  logic [3:0] e_vec, o_vec;

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // UART monitor: detects a start bit and samples each bit at mid-period.
  int         mon_t = -1;
  int         mon_b;
  logic [7:0] mon_v = '0;
  always @(negedge clk) begin
    if (reset) begin
      mon_t = -1;
    end else if (mon_t < 0) begin
      if (tx === 1'b0) mon_t = 0;
    end else begin
      mon_t++;
    end
    if (mon_t >= 0 && (mon_t % C) == C / 2) begin
      mon_b = mon_t / C;
      if (mon_b >= 1 && mon_b <= 8) mon_v[mon_b-1] = tx;
      if (mon_b == FRAME_BITS - 1) begin
        if (tx === STOP_BIT) rxq.push_back(mon_v);
        mon_t = -1;
      end
    end
  end

  task automatic drive_fifo();
    empty = (fq.size() == 0);
    rdata = empty ? 8'($urandom) : fq[0];
  endtask

  // One clock: evaluate the model at the negedge, capture DUT outputs,
  // then advance the model and the FIFO across the rising edge.
  task automatic tick();
    int b;
    @(negedge clk);
    e_rd = !reset && !empty && (m_pos < 0 || m_pos == FLEN - 1);
    if (m_pos < 0) begin
      e_tx = 1'b1;
    end else begin
      b = m_pos / C;
      if (b == 0)                   e_tx = START_BIT;
      else if (b == FRAME_BITS - 1) e_tx = STOP_BIT;
      else                          e_tx = m_byte[b-1];
    end
    e_vec = {e_rd, e_tx, (m_pos >= 0), (!reset && m_pos == FLEN - 1)};
    o_vec = {rd_en, tx, tx_busy, tx_done};
    @(posedge clk);
    if (reset)                 m_pos = -1;
    else if (e_rd)             begin m_byte = rdata; m_pos = 0; end
    else if (m_pos == FLEN-1)  m_pos = -1;
    else if (m_pos >= 0)       m_pos++;
    if (o_vec[3] && fq.size() > 0) fq.delete(0);
    cyc++;
    #1;
    drive_fifo();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    fq.delete();
    drive_fifo();
    @(posedge clk);
    #1;
    repeat (3) begin
      tick();
      n_cmp++;
      if (o_vec !== e_vec || o_vec !== 4'b0100) begin
        n_bad++;
        $display("FAIL reset_state {rd,tx,busy,done} got=%b exp=%b", o_vec, e_vec);
      end
    end
    fq.push_back(8'h99);
    drive_fifo();
    tick();
    n_cmp++;
    if (o_vec[3] !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_no_pop rd_en got=%b exp=0", o_vec[3]);
    end
    fq.delete();
    reset = 1'b0;
    drive_fifo();
  endtask

  task automatic test_single();
    int rd_n = 0, done_n = 0, busy_n = 0, rd_at = -1, done_at = -1;
    rxq.delete();
    repeat (10) begin
      tick();
      n_cmp++;
      if (o_vec !== e_vec) begin
        n_bad++;
        $display("FAIL single_idle cyc=%0d got=%b exp=%b", cyc, o_vec, e_vec);
      end
    end
    fq.push_back(8'h55);
    drive_fifo();
    repeat (48) begin
      tick();
      if (o_vec[3]) begin rd_n++; rd_at = cyc; end
      if (o_vec[0]) begin done_n++; done_at = cyc; end
      if (o_vec[1]) busy_n++;
      n_cmp++;
      if (o_vec !== e_vec) begin
        n_bad++;
        $display("FAIL single_frame cyc=%0d got=%b exp=%b", cyc, o_vec, e_vec);
      end
    end
    n_cmp++;
    if (rd_n != 1 || done_n != 1 || busy_n != 40 || done_at - rd_at != 40) begin
      n_bad++;
      $display("FAIL single_counts rd=%0d done=%0d busy=%0d gap=%0d exp 1/1/40/40",
               rd_n, done_n, busy_n, done_at - rd_at);
    end
    n_cmp++;
    if (rxq.size() != 1 || rxq[0] !== 8'h55) begin
      n_bad++;
      $display("FAIL single_rx got n=%0d b=%h exp n=1 b=55", rxq.size(),
               (rxq.size() > 0) ? rxq[0] : 8'hxx);
    end
  endtask

  task automatic test_back_to_back();
    int rd_at[$];
    int done_at[$];
    int busy_n = 0;
    rxq.delete();
    fq.push_back(8'hA5);
    fq.push_back(8'h3C);
    drive_fifo();
    repeat (90) begin
      tick();
      if (o_vec[3]) rd_at.push_back(cyc);
      if (o_vec[0]) done_at.push_back(cyc);
      if (o_vec[1]) busy_n++;
      n_cmp++;
      if (o_vec !== e_vec) begin
        n_bad++;
        $display("FAIL b2b_frame cyc=%0d got=%b exp=%b", cyc, o_vec, e_vec);
      end
    end
    n_cmp++;
    if (rd_at.size() != 2 || done_at.size() != 2 || busy_n != 80) begin
      n_bad++;
      $display("FAIL b2b_counts rd=%0d done=%0d busy=%0d exp 2/2/80",
               rd_at.size(), done_at.size(), busy_n);
    end else begin
      n_cmp++;
      if (rd_at[1] - rd_at[0] != 40 || done_at[0] != rd_at[1]) begin
        n_bad++;
        $display("FAIL b2b_timing rd_gap=%0d done0-rd1=%0d exp 40/0",
                 rd_at[1] - rd_at[0], done_at[0] - rd_at[1]);
      end
    end
    n_cmp++;
    if (rxq.size() != 2 || rxq[0] !== 8'hA5 || rxq[1] !== 8'h3C) begin
      n_bad++;
      $display("FAIL b2b_rx got n=%0d exp A5,3C", rxq.size());
    end
  endtask

  task automatic test_always_empty();
    repeat (500) begin
      tick();
      n_cmp++;
      if (o_vec !== e_vec || o_vec !== 4'b0100) begin
        n_bad++;
        $display("FAIL always_empty cyc=%0d got=%b exp=0100", cyc, o_vec);
      end
    end
  endtask

  task automatic test_reset_mid();
    int rd_n = 0;
    rxq.delete();
    fq.push_back(8'hFF);
    drive_fifo();
    tick();
    n_cmp++;
    if (o_vec !== e_vec || o_vec[3] !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid_pop got=%b exp=%b", o_vec, e_vec);
    end
    repeat (15) begin
      tick();
      n_cmp++;
      if (o_vec !== e_vec) begin
        n_bad++;
        $display("FAIL rstmid_pre cyc=%0d got=%b exp=%b", cyc, o_vec, e_vec);
      end
    end
    fq.push_back(8'h5A);
    drive_fifo();
    reset = 1'b1;
    tick();
    n_cmp++;
    if (o_vec !== e_vec || o_vec[3] !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_during got=%b exp=%b", o_vec, e_vec);
    end
    reset = 1'b0;
    tick();
    n_cmp++;
    if (o_vec !== e_vec || o_vec !== 4'b1100) begin
      n_bad++;
      $display("FAIL rstmid_after got=%b exp=1100", o_vec);
    end
    repeat (45) begin
      tick();
      if (o_vec[3]) rd_n++;
      n_cmp++;
      if (o_vec !== e_vec) begin
        n_bad++;
        $display("FAIL rstmid_frame cyc=%0d got=%b exp=%b", cyc, o_vec, e_vec);
      end
    end
    n_cmp++;
    if (rd_n != 0 || rxq.size() != 1 || rxq[0] !== 8'h5A) begin
      n_bad++;
      $display("FAIL rstmid_rx extra_pops=%0d n=%0d exp 0 pops, one byte 5A",
               rd_n, rxq.size());
    end
  endtask

  task automatic test_fifo_integration();
    int rd_n = 0;
    rxq.delete();
    for (int i = 1; i <= DEPTH; i++) fq.push_back(8'(i));
    drive_fifo();
    tick();
    if (o_vec[3]) rd_n++;
    n_cmp++;
    if (fq.size() != DEPTH - 1) begin
      n_bad++;
      $display("FAIL fifo_full_falls level=%0d exp=%0d", fq.size(), DEPTH - 1);
    end
    repeat (DEPTH * FLEN + 10) begin
      tick();
      if (o_vec[3]) rd_n++;
      n_cmp++;
      if (o_vec !== e_vec) begin
        n_bad++;
        $display("FAIL fifo_frame cyc=%0d got=%b exp=%b", cyc, o_vec, e_vec);
      end
    end
    n_cmp++;
    if (rd_n != DEPTH || fq.size() != 0 || o_vec[1] !== 1'b0) begin
      n_bad++;
      $display("FAIL fifo_drain pops=%0d level=%0d busy=%b exp 8/0/0",
               rd_n, fq.size(), o_vec[1]);
    end
    for (int i = 0; i < DEPTH; i++) begin
      n_cmp++;
      if (i >= rxq.size() || rxq[i] !== 8'(i + 1)) begin
        n_bad++;
        $display("FAIL fifo_rx idx=%0d got=%h exp=%h", i,
                 (i < rxq.size()) ? rxq[i] : 8'hxx, 8'(i + 1));
      end
    end
  endtask

  task automatic test_write_during_frame();
    int rd_at[$];
    rxq.delete();
    fq.push_back(8'h33);
    drive_fifo();
    for (int i = 0; i < 95; i++) begin
      if (i == 16) begin
        fq.push_back(8'h77);
        drive_fifo();
      end
      tick();
      if (o_vec[3]) rd_at.push_back(cyc);
      n_cmp++;
      if (o_vec !== e_vec) begin
        n_bad++;
        $display("FAIL wdf_frame cyc=%0d got=%b exp=%b", cyc, o_vec, e_vec);
      end
    end
    n_cmp++;
    if (rd_at.size() != 2 || rd_at[1] - rd_at[0] != FLEN) begin
      n_bad++;
      $display("FAIL wdf_timing pops=%0d exp 2 pops %0d apart", rd_at.size(), FLEN);
    end
    n_cmp++;
    if (rxq.size() != 2 || rxq[0] !== 8'h33 || rxq[1] !== 8'h77) begin
      n_bad++;
      $display("FAIL wdf_rx n=%0d exp 33,77", rxq.size());
    end
  endtask

  task automatic test_random();
    logic [7:0] sent[$];
    logic [7:0] b;
    int         guard = 0;
    rxq.delete();
    repeat (1500) begin
      if (fq.size() < DEPTH && $urandom_range(29, 0) == 0) begin
        b = 8'($urandom);
        fq.push_back(b);
        sent.push_back(b);
        drive_fifo();
      end
      tick();
      n_cmp++;
      if (o_vec !== e_vec) begin
        n_bad++;
        $display("FAIL random cyc=%0d got=%b exp=%b", cyc, o_vec, e_vec);
      end
    end
    while ((fq.size() != 0 || m_pos >= 0) && guard < 500) begin
      tick();
      guard++;
      n_cmp++;
      if (o_vec !== e_vec) begin
        n_bad++;
        $display("FAIL random_drain cyc=%0d got=%b exp=%b", cyc, o_vec, e_vec);
      end
    end
    repeat (5) tick();
    n_cmp++;
    if (guard >= 500) begin
      n_bad++;
      $display("FAIL random_drain_timeout level=%0d exp=0", fq.size());
    end
    n_cmp++;
    if (rxq.size() != sent.size()) begin
      n_bad++;
      $display("FAIL random_rx_count got=%0d exp=%0d", rxq.size(), sent.size());
    end else begin
      for (int i = 0; i < sent.size(); i++) begin
        n_cmp++;
        if (rxq[i] !== sent[i]) begin
          n_bad++;
          $display("FAIL random_rx idx=%0d got=%h exp=%h", i, rxq[i], sent[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_always_empty();
    test_reset_mid();
    test_fifo_integration();
    test_write_during_frame();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_fifo_uart_tx
`default_nettype wire
